// File: rtl/fetch_stage.sv
// Instruction fetch front end: PC register, credit-limited imem request port,
// in-order fetch buffer with bypass, and redirect squash. Optional FETCH_STATS_EN adds counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSN   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        pc_src_mem,
    input  logic [31:0] target_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc_if,
    output logic [31:0] pc_plus_4_if,
    output logic        valid_if
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] redirect_count,
    output logic [31:0] bubble_count
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]   buf_count_q, buf_count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]        buf_insn_q [FIFO_DEPTH];
    logic [31:0]        buf_insn_d [FIFO_DEPTH];
    logic [31:0]        buf_pc_q [FIFO_DEPTH];
    logic [31:0]        buf_pc_d [FIFO_DEPTH];
    logic               req_q, req_d;
    logic [31:0]        insn_q, insn_d;
    logic [31:0]        pc_if_q, pc_if_d;
    logic [31:0]        pc4_q, pc4_d;
    logic               valid_q, valid_d;
    logic               fresh_q, fresh_d;

    logic               grant;
    logic               resp_live;
    logic               push;
    logic               pop;
    logic               bypass;

`ifdef FETCH_STATS_EN
    logic [31:0]        redir_cnt_q, redir_cnt_d;
    logic [31:0]        bubble_cnt_q, bubble_cnt_d;
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (int'(p) == FIFO_DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        drop_cnt_d    = drop_cnt_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        buf_insn_d    = buf_insn_q;
        buf_pc_d      = buf_pc_q;
        insn_d        = insn_q;
        pc_if_d       = pc_if_q;
        pc4_d         = pc4_q;
        valid_d       = valid_q;
        fresh_d       = fresh_q;
        push          = 1'b0;
        pop           = 1'b0;
        bypass        = 1'b0;

        grant = req_q & imem_gnt;
        // Responses with nothing in flight (e.g. left over from before reset) are ignored.
        resp_live = imem_rvalid && (outstanding_q != '0);

        if (grant) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            fresh_d    = 1'b0;
        end
        outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(resp_live);

        if (pc_src_mem) begin
            fetch_pc_d  = target_pc & ~32'h3;
            resp_pc_d   = target_pc & ~32'h3;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            insn_d      = NOP_INSN;
            valid_d     = 1'b0;
            drop_cnt_d  = (state_q == FLUSH) ? drop_cnt_q - CNT_W'(resp_live) : outstanding_d;
            state_d     = (state_q == FLUSH || outstanding_d != '0) ? FLUSH : RUN;
            buf_count_d = '0;
        end else begin
            if (state_q == FLUSH) begin
                drop_cnt_d = drop_cnt_q - CNT_W'(resp_live);
                if (drop_cnt_d == '0) begin
                    state_d = RUN;
                end
            end else if (resp_live) begin
                resp_pc_d = resp_pc_q + 32'd4;
                if (buf_count_q == '0 && !stall) begin
                    bypass = 1'b1;
                end else begin
                    push = 1'b1;
                end
            end

            if (!stall) begin
                if (buf_count_q != '0) begin
                    pop     = 1'b1;
                    insn_d  = buf_insn_q[rd_ptr_q];
                    pc_if_d = buf_pc_q[rd_ptr_q];
                    pc4_d   = buf_pc_q[rd_ptr_q] + 32'd4;
                    valid_d = 1'b1;
                end else if (bypass) begin
                    insn_d  = imem_rdata;
                    pc_if_d = resp_pc_q;
                    pc4_d   = resp_pc_q + 32'd4;
                    valid_d = 1'b1;
                end else begin
                    insn_d  = NOP_INSN;
                    valid_d = 1'b0;
                end
            end

            if (push) begin
                buf_insn_d[wr_ptr_q] = imem_rdata;
                buf_pc_d[wr_ptr_q]   = resp_pc_q;
                wr_ptr_d             = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            buf_count_d = buf_count_q + CNT_W'(push) - CNT_W'(pop);
        end

        // Request is registered, so it naturally drops for the cycle after a redirect.
        req_d = (state_d == RUN) && !pc_src_mem &&
                ((int'(buf_count_d) + int'(outstanding_d)) < FIFO_DEPTH);

`ifdef FETCH_STATS_EN
        redir_cnt_d  = redir_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (pc_src_mem && redir_cnt_q != 32'hFFFF_FFFF) begin
            redir_cnt_d = redir_cnt_q + 32'd1;
        end
        if (!stall && !valid_d && bubble_cnt_q != 32'hFFFF_FFFF) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        buf_insn_q <= buf_insn_d;
        buf_pc_q   <= buf_pc_d;
        if (rst) begin
            state_q       <= RUN;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            buf_count_q   <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            req_q         <= 1'b0;
            insn_q        <= NOP_INSN;
            pc_if_q       <= 32'h0;
            pc4_q         <= 32'h0;
            valid_q       <= 1'b0;
            fresh_q       <= 1'b1;
`ifdef FETCH_STATS_EN
            redir_cnt_q   <= 32'h0;
            bubble_cnt_q  <= 32'h0;
`endif
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            buf_count_q   <= buf_count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            req_q         <= req_d;
            insn_q        <= insn_d;
            pc_if_q       <= pc_if_d;
            pc4_q         <= pc4_d;
            valid_q       <= valid_d;
            fresh_q       <= fresh_d;
`ifdef FETCH_STATS_EN
            redir_cnt_q   <= redir_cnt_d;
            bubble_cnt_q  <= bubble_cnt_d;
`endif
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && imem_rvalid && !fresh_q) begin
            assert (outstanding_q != '0 || drop_cnt_q != '0)
                else $error("fetch_stage: imem_rvalid with nothing outstanding");
        end
    end
`endif

    assign imem_req     = req_q;
    assign imem_addr    = fetch_pc_q;
    assign instruction  = insn_q;
    assign pc_if        = pc_if_q;
    assign pc_plus_4_if = pc4_q;
    assign valid_if     = valid_q;
`ifdef FETCH_STATS_EN
    assign redirect_count = redir_cnt_q;
    assign bubble_count   = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage: per-cycle input vectors with
// hand-computed expected outputs, plus short hand-written reset and handshake sequences.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        pc_src_mem = 1'b0;
    logic [31:0] target_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instruction;
    logic [31:0] pc_if;
    logic [31:0] pc_plus_4_if;
    logic        valid_if;
`ifdef FETCH_STATS_EN
    logic [31:0] redirect_count;
    logic [31:0] bubble_count;
`endif

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .pc_src_mem   (pc_src_mem),
        .target_pc    (target_pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .instruction  (instruction),
        .pc_if        (pc_if),
        .pc_plus_4_if (pc_plus_4_if),
        .valid_if     (valid_if)
`ifdef FETCH_STATS_EN
        ,
        .redirect_count (redirect_count),
        .bubble_count   (bubble_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [31:0] tgt;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_insn;
        logic [31:0] e_pc;
        logic [31:0] e_pc4;
    } vec_t;

    localparam int NV = 31;
    vec_t vt [NV];

    int total = 0;
    int passed = 0;

    // Memory contents: instruction word derived from its address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic vec_t mk(input logic r, input logic s, input logic rd,
                                input logic [31:0] t, input logic g, input logic v,
                                input logic [31:0] ra, input logic er,
                                input logic [31:0] ea, input logic ev,
                                input logic [31:0] ep, input logic [31:0] ep4);
        vec_t x;
        x.rst = r; x.stall = s; x.redir = rd; x.tgt = t; x.gnt = g; x.rv = v;
        x.rdata = mem_word(ra);
        x.e_req = er; x.e_addr = ea; x.e_valid = ev;
        x.e_insn = ev ? mem_word(ep) : NOP;
        x.e_pc = ep; x.e_pc4 = ep4;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    initial begin
        //          rst s  rd tgt           g  v  raddr         req addr          vld pc            pc4
        vt[0]  = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0);
        vt[1]  = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0);
        vt[2]  = mk(0, 0, 0, 32'h0,        1, 1, 32'h0,        1, 32'h4,        0, 32'h0,        32'h0);
        vt[3]  = mk(0, 0, 0, 32'h0,        1, 1, 32'h4,        1, 32'h8,        1, 32'h0,        32'h4);
        vt[4]  = mk(0, 1, 0, 32'h0,        1, 1, 32'h8,        1, 32'hC,        1, 32'h4,        32'h8);
        vt[5]  = mk(0, 1, 0, 32'h0,        1, 1, 32'hC,        0, 32'h0,        1, 32'h4,        32'h8);
        vt[6]  = mk(0, 1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        1, 32'h4,        32'h8);
        vt[7]  = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        1, 32'h4,        32'h8);
        vt[8]  = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h10,       1, 32'h8,        32'hC);
        vt[9]  = mk(0, 0, 0, 32'h0,        1, 1, 32'h10,       1, 32'h14,       1, 32'hC,        32'h10);
        vt[10] = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h18,       1, 32'h10,       32'h14);
        vt[11] = mk(0, 0, 1, 32'h100,      1, 0, 32'h0,        0, 32'h0,        0, 32'h10,       32'h14);
        vt[12] = mk(0, 0, 0, 32'h0,        1, 1, 32'h14,       0, 32'h0,        0, 32'h10,       32'h14);
        vt[13] = mk(0, 0, 0, 32'h0,        1, 1, 32'h18,       0, 32'h0,        0, 32'h10,       32'h14);
        vt[14] = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h100,      0, 32'h10,       32'h14);
        vt[15] = mk(0, 0, 0, 32'h0,        1, 1, 32'h100,      1, 32'h104,      0, 32'h10,       32'h14);
        vt[16] = mk(0, 0, 1, 32'h203,      1, 1, 32'h104,      1, 32'h108,      1, 32'h100,      32'h104);
        vt[17] = mk(0, 0, 0, 32'h0,        1, 1, 32'h108,      0, 32'h0,        0, 32'h100,      32'h104);
        vt[18] = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h200,      0, 32'h100,      32'h104);
        vt[19] = mk(0, 0, 0, 32'h0,        1, 1, 32'h200,      1, 32'h204,      0, 32'h100,      32'h104);
        vt[20] = mk(0, 0, 1, 32'hFFFF_FFFC, 0, 1, 32'h204,     1, 32'h208,      1, 32'h200,      32'h204);
        vt[21] = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        0, 32'h200,      32'h204);
        vt[22] = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'hFFFF_FFFC, 0, 32'h200,     32'h204);
        vt[23] = mk(0, 0, 0, 32'h0,        1, 1, 32'hFFFF_FFFC, 1, 32'h0,       0, 32'h200,      32'h204);
        vt[24] = mk(0, 0, 1, 32'h40,       0, 0, 32'h0,        1, 32'h4,        1, 32'hFFFF_FFFC, 32'h0);
        vt[25] = mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'hFFFF_FFFC, 32'h0);
        vt[26] = mk(0, 0, 0, 32'h0,        1, 1, 32'h999,      0, 32'h0,        0, 32'h0,        32'h0);
        vt[27] = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0);
        vt[28] = mk(0, 0, 0, 32'h0,        0, 1, 32'h0,        1, 32'h4,        0, 32'h0,        32'h0);
        vt[29] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h4,        1, 32'h0,        32'h4);
        vt[30] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h4,        0, 32'h0,        32'h4);

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset req", {31'h0, imem_req}, 32'h0);
        chk("reset valid", {31'h0, valid_if}, 32'h0);
        chk("reset insn", instruction, NOP);
        chk("reset pc_if", pc_if, 32'h0);
        chk("reset pc4", pc_plus_4_if, 32'h0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            chk($sformatf("row%0d req", i), {31'h0, imem_req}, {31'h0, vt[i].e_req});
            if (vt[i].e_req) chk($sformatf("row%0d addr", i), imem_addr, vt[i].e_addr);
            chk($sformatf("row%0d valid", i), {31'h0, valid_if}, {31'h0, vt[i].e_valid});
            chk($sformatf("row%0d insn", i), instruction, vt[i].e_insn);
            chk($sformatf("row%0d pc_if", i), pc_if, vt[i].e_pc);
            chk($sformatf("row%0d pc4", i), pc_plus_4_if, vt[i].e_pc4);
            rst         = vt[i].rst;
            stall       = vt[i].stall;
            pc_src_mem  = vt[i].redir;
            target_pc   = vt[i].tgt;
            imem_gnt    = vt[i].gnt;
            imem_rvalid = vt[i].rv;
            imem_rdata  = vt[i].rdata;
        end

        // Bounded wait for the pending request, then one grant/response round trip.
        begin
            int k;
            k = 0;
            @(negedge clk);
            while (!imem_req && k < 5) begin
                @(negedge clk);
                k++;
            end
            chk("handshake req seen", {31'h0, imem_req}, 32'h1);
            chk("handshake addr", imem_addr, 32'h4);
            imem_gnt = 1'b1;
            @(negedge clk);
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(32'h4);
            @(negedge clk);
            imem_rvalid = 1'b0;
            chk("handshake valid", {31'h0, valid_if}, 32'h1);
            chk("handshake insn", instruction, mem_word(32'h4));
            chk("handshake pc_if", pc_if, 32'h4);
            chk("handshake pc4", pc_plus_4_if, 32'h8);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
